// File: rtl/pcm_mux_fifo.sv
// pcm_mux_fifo: selects one of CHANNEL signed PCM streams, decimates it and
// queues the kept samples in a first-word-fall-through FIFO of 2^PCMAW words.
// Optional gain stage (signed multiply, arithmetic shift, truncation) is
// built when the macro PCM_MUX_FIFO_GAIN_EN is defined.
module pcm_mux_fifo #(
    parameter int CHANNEL = 2,
    parameter int PCMAW   = 1
) (
    input  logic                  pcm_clk,
    input  logic                  rst_n,
    input  logic [CHANNEL-1:0]    pcm_in_valid,
    output logic [CHANNEL-1:0]    pcm_in_ready,
    input  logic [16*CHANNEL-1:0] pcm_in,
    output logic                  pcm_out_valid,
    input  logic                  pcm_out_ready,
    output logic [15:0]           pcm_out,
    input  logic [7:0]            pcm_channel_choose,
    input  logic [7:0]            pcm_capture_sep,
`ifdef PCM_MUX_FIFO_GAIN_EN
    input  logic signed [15:0]    gain,
    input  logic [3:0]            gain_shift,
`endif
    output logic [PCMAW:0]        pcm_available
);

    localparam int               DEPTH   = 1 << PCMAW;
    localparam logic [PCMAW+1:0] DEPTH_W = (PCMAW+2)'(DEPTH);
    localparam logic [PCMAW:0]   PTR_ONE = (PCMAW+1)'(1);
    localparam logic [7:0]       CH_N    = 8'(CHANNEL);

    logic signed [15:0] mem [DEPTH];
    logic [PCMAW:0]     wr_ptr;
    logic [PCMAW:0]     rd_ptr;
    logic [PCMAW:0]     occupancy;
    logic [PCMAW+1:0]   demand;
    logic [7:0]         cnt;
    logic [7:0]         choose_q;
    logic               sel_ok;
    logic               sel_valid;
    logic signed [15:0] sel_data;
    logic               sel_ready;
    logic               accept;
    logic               capture;
    logic [1:0]         in_flight;
    logic               full;
    logic               empty;
    logic               pop;
    logic               wr_en;
    logic signed [15:0] wr_data;

    assign occupancy     = wr_ptr - rd_ptr;
    assign full          = (wr_ptr[PCMAW] != rd_ptr[PCMAW]) &&
                           (wr_ptr[PCMAW-1:0] == rd_ptr[PCMAW-1:0]);
    assign empty         = (wr_ptr == rd_ptr);
    assign pcm_out_valid = !empty;
    assign pcm_out       = pcm_out_valid ? mem[rd_ptr[PCMAW-1:0]] : 16'h0000;
    assign pop           = pcm_out_valid && pcm_out_ready;
    assign pcm_available = occupancy;

    // Samples already on their way into the FIFO must reserve a slot too.
    assign sel_ok    = (pcm_channel_choose < CH_N);
    assign demand    = {1'b0, occupancy} + {{PCMAW{1'b0}}, in_flight};
    assign sel_ready = (cnt != 8'd0) || (demand < DEPTH_W);
    assign accept    = sel_ok && sel_valid && sel_ready;
    assign capture   = accept && (cnt == 8'd0);

    // Channel mux and per-channel ready; non-selected channels always drain.
    always_comb begin
        sel_valid    = 1'b0;
        sel_data     = '0;
        pcm_in_ready = '1;
        for (int k = 0; k < CHANNEL; k++) begin
            if (pcm_channel_choose == 8'(k)) begin
                sel_valid       = pcm_in_valid[k];
                sel_data        = pcm_in[16*k +: 16];
                pcm_in_ready[k] = sel_ok ? sel_ready : 1'b1;
            end
        end
    end

`ifdef PCM_MUX_FIFO_GAIN_EN
    logic signed [15:0] data_p0;
    logic               vld_p0;
    logic signed [31:0] prod_p1;
    logic               vld_p1;

    // Arithmetic right shift of the product, low 16 bits kept (wraps on overflow).
    function automatic logic signed [15:0] scale(input logic signed [31:0] prod,
                                                 input logic [3:0]         sh);
        logic signed [31:0] shifted;
        shifted = prod >>> sh;
        return shifted[15:0];
    endfunction

    // Gain pipeline valid flags; cleared by reset so in-flight samples are dropped.
    always_ff @(posedge pcm_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= capture;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p0: captured sample; stage p1: full-precision signed product.
    always_ff @(posedge pcm_clk) begin
        if (capture) begin
            data_p0 <= sel_data;
        end
        prod_p1 <= 32'(data_p0) * 32'(gain);
    end

    assign in_flight = {1'b0, vld_p0} + {1'b0, vld_p1};
    assign wr_en     = vld_p1;
    assign wr_data   = scale(prod_p1, gain_shift);
`else
    assign in_flight = 2'd0;
    assign wr_en     = capture;
    assign wr_data   = sel_data;
`endif

    // Pointers, decimation counter and selection tracking.
    always_ff @(posedge pcm_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= 8'd0;
            choose_q <= 8'd0;
        end else begin
            choose_q <= pcm_channel_choose;
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (pcm_channel_choose != choose_q) begin
                cnt <= 8'd0;
            end else if (accept) begin
                cnt <= (cnt >= pcm_capture_sep) ? 8'd0 : cnt + 8'd1;
            end
        end
    end

    // FIFO storage write port; contents are deliberately not reset.
    always_ff @(posedge pcm_clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[PCMAW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_pcm_mux_fifo.sv
// Self-checking bench for pcm_mux_fifo (CHANNEL=2, PCMAW=1). Works with or
// without PCM_MUX_FIFO_GAIN_EN; the reference model is a queue-based view of
// the FIFO plus a list of samples still travelling through the gain pipeline.
module tb_pcm_mux_fifo;

    localparam int CH    = 2;
    localparam int AW    = 1;
    localparam int DEPTH = 1 << AW;
`ifdef PCM_MUX_FIFO_GAIN_EN
    localparam int LAT   = 3;
`else
    localparam int LAT   = 1;
`endif

    logic              pcm_clk = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     pcm_in_valid;
    logic [CH-1:0]     pcm_in_ready;
    logic [16*CH-1:0]  pcm_in;
    logic              pcm_out_valid;
    logic              pcm_out_ready;
    logic [15:0]       pcm_out;
    logic [7:0]        pcm_channel_choose;
    logic [7:0]        pcm_capture_sep;
    logic [AW:0]       pcm_available;
`ifdef PCM_MUX_FIFO_GAIN_EN
    logic [15:0]       gain;
    logic [3:0]        gain_shift;
`endif

    int checks = 0;
    int passed = 0;

    logic [15:0] m_fifo[$];
    logic [15:0] m_pipe_d[$];
    int          m_pipe_age[$];
    int          m_cnt;
    int          m_prev;

    pcm_mux_fifo #(.CHANNEL(CH), .PCMAW(AW)) dut (
        .pcm_clk            (pcm_clk),
        .rst_n              (rst_n),
        .pcm_in_valid       (pcm_in_valid),
        .pcm_in_ready       (pcm_in_ready),
        .pcm_in             (pcm_in),
        .pcm_out_valid      (pcm_out_valid),
        .pcm_out_ready      (pcm_out_ready),
        .pcm_out            (pcm_out),
        .pcm_channel_choose (pcm_channel_choose),
        .pcm_capture_sep    (pcm_capture_sep),
`ifdef PCM_MUX_FIFO_GAIN_EN
        .gain               (gain),
        .gain_shift         (gain_shift),
`endif
        .pcm_available      (pcm_available)
    );

    always #5 pcm_clk = ~pcm_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    task automatic model_reset();
        m_fifo.delete();
        m_pipe_d.delete();
        m_pipe_age.delete();
        m_cnt  = 0;
        m_prev = 0;
    endtask

    task automatic model_outputs(output logic [CH-1:0] rdy, output logic vld,
                                 output logic [15:0] dout, output logic [AW:0] avail);
        int ch;
        ch  = int'(pcm_channel_choose);
        rdy = '1;
        if (ch < CH) rdy[ch] = (m_cnt != 0) || (m_fifo.size() + m_pipe_d.size() < DEPTH);
        vld   = (m_fifo.size() != 0);
        dout  = vld ? m_fifo[0] : 16'h0000;
        avail = (AW+1)'(m_fifo.size());
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        int          ch;
        logic        acc;
        logic        cap;
        logic [15:0] s;
        logic [15:0] v;
        ch  = int'(pcm_channel_choose);
        acc = 1'b0;
        s   = 16'h0000;
        if (ch < CH) begin
            s   = pcm_in[16*ch +: 16];
            acc = pcm_in_valid[ch] &&
                  ((m_cnt != 0) || (m_fifo.size() + m_pipe_d.size() < DEPTH));
        end
        cap = acc && (m_cnt == 0);
        if (m_fifo.size() != 0 && pcm_out_ready) void'(m_fifo.pop_front());
        foreach (m_pipe_age[i]) m_pipe_age[i] = m_pipe_age[i] - 1;
        while (m_pipe_age.size() != 0 && m_pipe_age[0] == 0) begin
            m_fifo.push_back(m_pipe_d.pop_front());
            void'(m_pipe_age.pop_front());
        end
        if (cap) begin
`ifdef PCM_MUX_FIFO_GAIN_EN
            begin
                logic signed [31:0] p;
                p = 32'($signed(s)) * 32'($signed(gain));
                p = p >>> gain_shift;
                v = p[15:0];
                m_pipe_d.push_back(v);
                m_pipe_age.push_back(2);
            end
`else
            v = s;
            m_fifo.push_back(v);
`endif
        end
        if (ch != m_prev) m_cnt = 0;
        else if (acc) m_cnt = (m_cnt >= int'(pcm_capture_sep)) ? 0 : m_cnt + 1;
        m_prev = ch;
    endtask

    task automatic do_reset();
        @(negedge pcm_clk);
        rst_n         = 1'b0;
        pcm_in_valid  = '0;
        pcm_out_ready = 1'b0;
        repeat (2) @(negedge pcm_clk);
        rst_n = 1'b1;
        model_reset();
        model_edge();
    endtask

    task automatic test_reset();
        @(negedge pcm_clk);
        rst_n              = 1'b1;
        pcm_channel_choose = 8'd0;
        pcm_capture_sep    = 8'd0;
        pcm_out_ready      = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge pcm_clk);
            pcm_in_valid = 2'b11;
            pcm_in       = {16'hBEEF, 16'(16'h0100 + c)};
        end
        #1;
        checks++;
        if (pcm_available !== 2'd2) $display("FAIL reset_preload: available=%0d expected=2", pcm_available);
        else passed++;
        #1 rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (pcm_out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", pcm_out_valid);
            else passed++;
            checks++;
            if (pcm_available !== 2'd0) $display("FAIL reset_available: got %0d expected 0", pcm_available);
            else passed++;
            checks++;
            if (pcm_out !== 16'h0000) $display("FAIL reset_out: got %h expected 0000", pcm_out);
            else passed++;
            checks++;
            if (pcm_in_ready !== 2'b11) $display("FAIL reset_ready: got %b expected 11", pcm_in_ready);
            else passed++;
            @(negedge pcm_clk);
            pcm_in_valid  = 2'b11;
            pcm_in        = {16'($urandom), 16'($urandom)};
            pcm_out_ready = 1'($urandom);
        end
        pcm_in_valid  = '0;
        pcm_out_ready = 1'b0;
        rst_n         = 1'b1;
        model_reset();
        model_edge();
        @(negedge pcm_clk);
        #1;
        checks++;
        if (pcm_available !== 2'd0) $display("FAIL reset_discard_avail: got %0d expected 0", pcm_available);
        else passed++;
        checks++;
        if (pcm_out_valid !== 1'b0) $display("FAIL reset_discard_valid: got %b expected 0", pcm_out_valid);
        else passed++;
    endtask

    task automatic test_passthrough();
        int          idx;
        int          first;
        logic [15:0] got[$];
        do_reset();
        pcm_channel_choose = 8'd0;
        pcm_capture_sep    = 8'd0;
        pcm_out_ready      = 1'b1;
        idx   = 0;
        first = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge pcm_clk);
            pcm_in_valid = {1'b1, (idx < 4)};
            pcm_in       = {16'hAAAA, 16'(idx + 1)};
            #1;
            checks++;
            if (pcm_in_ready[1] !== 1'b1) $display("FAIL pass_ch1_ready: got %b expected 1", pcm_in_ready[1]);
            else passed++;
            if (pcm_out_valid) begin
                got.push_back(pcm_out);
                if (first < 0) first = c;
            end
            if (pcm_in_valid[0] && pcm_in_ready[0]) idx++;
        end
        pcm_in_valid = '0;
        checks++;
        if (got.size() != 4) $display("FAIL pass_count: got %0d expected 4", got.size());
        else passed++;
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== 16'(i + 1)) $display("FAIL pass_data[%0d]: got %h expected %h", i, got[i], 16'(i + 1));
            else passed++;
        end
        checks++;
        if (first != LAT) $display("FAIL pass_latency: got %0d expected %0d", first, LAT);
        else passed++;
    endtask

    task automatic test_decimation();
        int          idx;
        logic [15:0] got[$];
        do_reset();
        pcm_channel_choose = 8'd0;
        pcm_capture_sep    = 8'd3;
        pcm_out_ready      = 1'b1;
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge pcm_clk);
            pcm_in_valid = {1'b0, (idx < 12)};
            pcm_in       = {16'h5555, 16'(idx)};
            #1;
            if (pcm_out_valid) got.push_back(pcm_out);
            if (pcm_in_valid[0] && pcm_in_ready[0]) idx++;
        end
        pcm_in_valid = '0;
        checks++;
        if (got.size() != 3) $display("FAIL dec_count: got %0d expected 3", got.size());
        else passed++;
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i] !== 16'(4 * i)) $display("FAIL dec_data[%0d]: got %h expected %h", i, got[i], 16'(4 * i));
            else passed++;
        end
        pcm_capture_sep = 8'd0;
    endtask

    task automatic test_backpressure();
        logic [15:0] vals [3];
        int          idx;
        bit          early;
        bit          reached;
        vals[0] = 16'h1111;
        vals[1] = 16'h2222;
        vals[2] = 16'h3333;
        do_reset();
        pcm_channel_choose = 8'd0;
        pcm_capture_sep    = 8'd0;
        pcm_out_ready      = 1'b0;
        idx   = 0;
        early = 1'b0;
        for (int c = 0; c < 20 && !(idx == 2 && pcm_available == 2'd2); c++) begin
            @(negedge pcm_clk);
            pcm_in_valid = 2'b01;
            pcm_in       = {16'h0000, vals[idx]};
            #1;
            if (pcm_in_ready[0]) begin
                if (idx == 2) early = 1'b1;
                else idx++;
            end
        end
        checks++;
        if (idx != 2) $display("FAIL bp_two_accepted: got %0d expected 2", idx);
        else passed++;
        checks++;
        if (early) $display("FAIL bp_third_early: got accepted expected held");
        else passed++;
        checks++;
        if (pcm_available !== 2'd2) $display("FAIL bp_available: got %0d expected 2", pcm_available);
        else passed++;
        checks++;
        if (pcm_in_ready[0] !== 1'b0) $display("FAIL bp_ready_full: got %b expected 0", pcm_in_ready[0]);
        else passed++;
        @(negedge pcm_clk);
        pcm_out_ready = 1'b1;
        #1;
        checks++;
        if (pcm_out !== 16'h1111) $display("FAIL bp_head_a: got %h expected 1111", pcm_out);
        else passed++;
        checks++;
        if (pcm_in_ready[0] !== 1'b0) $display("FAIL bp_ready_popcycle: got %b expected 0", pcm_in_ready[0]);
        else passed++;
        @(negedge pcm_clk);
        pcm_out_ready = 1'b0;
        #1;
        checks++;
        if (pcm_in_ready[0] !== 1'b1) $display("FAIL bp_ready_after_pop: got %b expected 1", pcm_in_ready[0]);
        else passed++;
        @(negedge pcm_clk);
        pcm_in_valid = 2'b00;
        reached = 1'b0;
        for (int c = 0; c < 10 && !reached; c++) begin
            #1;
            if (pcm_available == 2'd2) reached = 1'b1;
            else @(negedge pcm_clk);
        end
        checks++;
        if (!reached) $display("FAIL bp_refill: got available=%0d expected 2", pcm_available);
        else passed++;
        checks++;
        if (pcm_out !== 16'h2222) $display("FAIL bp_head_b: got %h expected 2222", pcm_out);
        else passed++;
        @(negedge pcm_clk);
        pcm_out_ready = 1'b1;
        @(negedge pcm_clk);
        pcm_out_ready = 1'b0;
        #1;
        checks++;
        if (pcm_out !== 16'h3333) $display("FAIL bp_head_c: got %h expected 3333", pcm_out);
        else passed++;
    endtask

`ifdef PCM_MUX_FIFO_GAIN_EN
    task automatic test_gain();
        do_reset();
        gain               = 16'h0100;
        gain_shift         = 4'd8;
        pcm_channel_choose = 8'd0;
        pcm_capture_sep    = 8'd0;
        pcm_out_ready      = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge pcm_clk);
            pcm_in_valid = (c == 0) ? 2'b01 : 2'b00;
            pcm_in       = {16'h0000, 16'hFF80};
            #1;
            if (c == 0) begin
                checks++;
                if (pcm_in_ready[0] !== 1'b1) $display("FAIL gain_ready: got %b expected 1", pcm_in_ready[0]);
                else passed++;
            end else if (c < 3) begin
                checks++;
                if (pcm_out_valid !== 1'b0) $display("FAIL gain_early_valid c=%0d: got %b expected 0", c, pcm_out_valid);
                else passed++;
            end else begin
                checks++;
                if (pcm_out_valid !== 1'b1) $display("FAIL gain_valid c=%0d: got %b expected 1", c, pcm_out_valid);
                else passed++;
                checks++;
                if (pcm_out !== 16'hFF80) $display("FAIL gain_out c=%0d: got %h expected ff80", c, pcm_out);
                else passed++;
            end
        end
        gain       = 16'h0001;
        gain_shift = 4'd0;
    endtask
`endif

    task automatic test_invalid();
        do_reset();
        pcm_channel_choose = 8'd5;
        pcm_capture_sep    = 8'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge pcm_clk);
            pcm_in_valid  = 2'($urandom);
            pcm_in        = {16'($urandom), 16'($urandom)};
            pcm_out_ready = 1'($urandom);
            #1;
            checks++;
            if (pcm_in_ready !== 2'b11) $display("FAIL inv_ready: got %b expected 11", pcm_in_ready);
            else passed++;
            checks++;
            if (pcm_out_valid !== 1'b0 || pcm_available !== 2'd0)
                $display("FAIL inv_empty: got valid=%b avail=%0d expected 0/0", pcm_out_valid, pcm_available);
            else passed++;
        end
        pcm_in_valid       = '0;
        pcm_channel_choose = 8'd0;
    endtask

    task automatic test_random();
        logic [CH-1:0] e_rdy;
        logic          e_vld;
        logic [15:0]   e_out;
        logic [AW:0]   e_avail;
`ifdef PCM_MUX_FIFO_GAIN_EN
        gain       = 16'($urandom);
        gain_shift = 4'($urandom);
`endif
        pcm_channel_choose = 8'd0;
        pcm_capture_sep    = 8'd1;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
`ifdef PCM_MUX_FIFO_GAIN_EN
                gain       = 16'($urandom);
                gain_shift = 4'($urandom);
`endif
                do_reset();
            end
            @(negedge pcm_clk);
            if ($urandom_range(0, 24) == 0) pcm_channel_choose = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 39) == 0) pcm_capture_sep = 8'($urandom_range(0, 3));
            pcm_in_valid  = 2'($urandom);
            pcm_in        = {16'($urandom), 16'($urandom)};
            pcm_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            model_outputs(e_rdy, e_vld, e_out, e_avail);
            checks++;
            if (pcm_in_ready !== e_rdy) $display("FAIL rnd_ready c=%0d: got %b expected %b", c, pcm_in_ready, e_rdy);
            else passed++;
            checks++;
            if (pcm_out_valid !== e_vld) $display("FAIL rnd_valid c=%0d: got %b expected %b", c, pcm_out_valid, e_vld);
            else passed++;
            checks++;
            if (pcm_out !== e_out) $display("FAIL rnd_out c=%0d: got %h expected %h", c, pcm_out, e_out);
            else passed++;
            checks++;
            if (pcm_available !== e_avail) $display("FAIL rnd_avail c=%0d: got %0d expected %0d", c, pcm_available, e_avail);
            else passed++;
            model_edge();
        end
        pcm_in_valid = '0;
    endtask

    initial begin
        rst_n              = 1'b0;
        pcm_in_valid       = '0;
        pcm_in             = '0;
        pcm_out_ready      = 1'b0;
        pcm_channel_choose = 8'd0;
        pcm_capture_sep    = 8'd0;
`ifdef PCM_MUX_FIFO_GAIN_EN
        gain               = 16'h0001;
        gain_shift         = 4'd0;
`endif
        model_reset();
        test_reset();
        test_passthrough();
        test_decimation();
        test_backpressure();
`ifdef PCM_MUX_FIFO_GAIN_EN
        test_gain();
`endif
        test_invalid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pcm_mux_fifo.md
PCM_MUX_FIFO -- requirements
Module: pcm_mux_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named pcm_clk and rst_n.
REQ-002 Parameters SHALL be:
- CHANNEL, default 2: number of input channels, 1..8.
- PCMAW, default 1: FIFO address width; depth is 2^PCMAW words.
REQ-003 pcm_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pcm_in_valid  in  CHANNEL  per-channel sample valid.
REQ-006 pcm_in_ready  out  CHANNEL  per-channel sample ready.
REQ-007 pcm_in  in  16*CHANNEL  signed samples; channel k occupies bits [16k+15:16k].
REQ-008 pcm_out_valid  out  1  FIFO head valid.
REQ-009 pcm_out_ready  in  1  consumer pops the head.
REQ-010 pcm_out  out  16  FIFO head sample.
REQ-011 pcm_channel_choose  in  8  selected channel index.
REQ-012 pcm_capture_sep  in  8  decimation: capture one sample per (sep+1) accepted samples.
REQ-013 pcm_available  out  PCMAW+1  FIFO occupancy.
REQ-014 gain  in  16  signed multiplier; present only with PCM_MUX_FIFO_GAIN_EN.
REQ-015 gain_shift  in  4  right shift after multiply; present only with PCM_MUX_FIFO_GAIN_EN.

Function
REQ-016 Transfer rules: an input transfer SHALL occur when pcm_in_valid[k] and pcm_in_ready[k] are both high; a pop SHALL occur when pcm_out_valid and pcm_out_ready are both high.
REQ-017 Unselected channels SHALL hold pcm_in_ready=1 and their samples SHALL be discarded.
REQ-018 If pcm_channel_choose >= CHANNEL, all ready outputs SHALL be 1 and nothing SHALL be captured.
REQ-019 Decimation counter cnt, 8 bits:
- On each accepted selected-channel sample, the sample SHALL be captured iff cnt==0.
- cnt SHALL then become 0 if cnt >= pcm_capture_sep, otherwise cnt+1.
- sep=0 SHALL capture every sample.
REQ-020 Selected-channel pcm_in_ready SHALL be 1 when cnt!=0, or when occupancy plus in-flight samples < 2^PCMAW; otherwise 0, with cnt held.
REQ-021 Any change of pcm_channel_choose SHALL clear cnt to 0 on the next cycle; FIFO contents SHALL be kept.
REQ-022 The FIFO SHALL be first-word-fall-through:
- pcm_out_valid = (occupancy != 0).
- pcm_out = head word when valid, 0 otherwise.
REQ-023 Pointers SHALL be PCMAW+1 bits and wrap modulo 2^(PCMAW+1); full = (MSBs differ and the rest are equal); empty = (pointers equal).
REQ-024 Simultaneous write and pop SHALL leave occupancy unchanged; pop when empty SHALL be ignored; writes SHALL never overrun (guaranteed by REQ-020).
REQ-025 Latency from a captured input transfer to pcm_out_valid SHALL be 1 cycle without gain, 3 cycles with gain.
REQ-026 pcm_available SHALL equal the registered occupancy, 0..2^PCMAW.

Reset
REQ-027 While rst_n=0, the following SHALL be cleared:
- pointers, cnt and gain-pipeline valid flags set to 0;
- pcm_out_valid=0, pcm_out=0, pcm_available=0;
- pcm_in_ready driven to its REQ-017/018/020 value for an empty FIFO.
REQ-028 FIFO memory SHALL not be reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored and in-flight samples.

Configuration
REQ-030 Macro PCM_MUX_FIFO_GAIN_EN controls the gain stage. When defined:
- Each captured sample SHALL be multiplied signed 16x16 by gain to a 32-bit product through a 2-stage registered multiplier.
- The product SHALL be arithmetically shifted right by gain_shift, and bits [15:0] SHALL be written (truncation, no saturation).
- In-flight samples SHALL count toward the REQ-020 limit.
REQ-031 When PCM_MUX_FIFO_GAIN_EN is undefined, the gain and gain_shift ports SHALL be absent and samples SHALL be written unmodified.

Verification
REQ-032 Reset: rst_n=0 with traffic applied -> pcm_out_valid=0, pcm_available=0, pcm_out=0.
REQ-033 Passthrough: CHANNEL=2, choose=0, sep=0, samples 0x0001..0x0004 on ch0 with pcm_out_ready=1 -> same sequence out; ch1 ready stays 1 and its data never appears.
REQ-034 Decimation: sep=3, inputs 0..11 -> outputs 0, 4, 8.
REQ-035 Full/backpressure: PCMAW=1, pcm_out_ready=0, three samples offered -> first two stored, pcm_available=2, ready=0 on the third; one pop -> third accepted next cycle.
REQ-036 Gain (macro defined): gain=0x0100, gain_shift=8, input 0xFF80 (-128) -> output 0xFF80 three cycles later.
REQ-037 Invalid selection: choose=5 with CHANNEL=2 -> all ready=1, FIFO stays empty.
